// File: rtl/tbl_seed_loader_if.sv
// ---------------------------------------------------------------------------
// tbl_seed_loader_if
//   Valid/ready stream that carries 68-bit seed-table words into the loader.
//
//   in_data   word being offered by the source
//   in_valid  source has a word on in_data
//   in_ready  loader will take in_data on this edge
//
//   Modports:
//     master  upstream word source (drives data/valid, observes ready)
//     slave   tbl_seed_loader      (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface tbl_seed_loader_if #(
  parameter int DATA_W = 68
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/tbl_seed_loader.sv
// ---------------------------------------------------------------------------
// tbl_seed_loader
//   Front end of the 320x68 divide/sqrt seed table. A start pulse opens a
//   load window of `count` entries beginning at `start_addr`. Each word
//   taken from the stream becomes one table write one cycle later: data on
//   tbl_A, index on tbl_B[53:45]. busy stays high for the whole load,
//   including the final write strobe, so the math pipe holds off reads.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start           load request, only honoured in IDLE
//     start_addr      first table index
//     count           number of words to load (0..DEPTH)
//     stream          word stream (slave side of tbl_seed_loader_if)
//     tbl_A           table write data
//     tbl_B           table index in [53:45], other bits zero
//     tbl_is_write    table write strobe
//     busy            load in progress
//     done            one-cycle pulse when a load completes
//     err             one-cycle pulse when a start is out of range
//
//   Optional feature, enabled by defining TBL_SEED_LOADER_CKSUM_EN:
//     exp_cksum       expected XOR of all loaded words, sampled with start
//     cksum           running XOR of the words accepted in this load
//     cksum_err       one-cycle pulse alongside done when cksum mismatches
// ---------------------------------------------------------------------------
module tbl_seed_loader #(
  parameter int DEPTH   = 320,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 68
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   count,
  tbl_seed_loader_if.slave    stream,
`ifdef TBL_SEED_LOADER_CKSUM_EN
  input  logic [DATA_W-1:0]   exp_cksum,
  output logic [DATA_W-1:0]   cksum,
  output logic                cksum_err,
`endif
  output logic [DATA_W-1:0]   tbl_A,
  output logic [DATA_W-1:0]   tbl_B,
  output logic                tbl_is_write,
  output logic                busy,
  output logic                done,
  output logic                err
);

  // Bit position of the table index inside tbl_B.
  localparam int IDX_LSB = 45;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  rem_q;

  logic [ADDR_W:0]    end_sum;
  logic               range_ok;
  logic               start_idle;
  logic               load_go;
  logic               accept;
  logic [DATA_W-1:0]  b_word;

  // One extra bit on the sum so an oversized request can never wrap back
  // into a low (legal-looking) index.
  assign end_sum    = {1'b0, start_addr} + {1'b0, count};
  assign range_ok   = (end_sum <= DEPTH_X);
  assign start_idle = start && (state_q == S_IDLE);
  assign load_go    = start_idle && range_ok && (count != '0);
  assign accept     = (state_q == S_LOAD) && stream.in_valid;

  // NOTE: every signal written in an always_comb gets a default first, so
  // no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    b_word  = '0;
    b_word[IDX_LSB +: ADDR_W] = addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && range_ok) begin
          state_d = (count == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept && (rem_q == ADDR_W'(1))) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign stream.in_ready = (state_q == S_LOAD);
  assign busy            = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign done            = (state_q == S_DONE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      tbl_A        <= '0;
      tbl_B        <= '0;
      tbl_is_write <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      tbl_is_write <= accept;
      err          <= start_idle && !range_ok;

      if (load_go) begin
        addr_q <= start_addr;
        rem_q  <= count;
      end else if (accept) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - ADDR_W'(1);
      end

      // tbl_A/tbl_B hold their last write between strobes.
      if (accept) begin
        tbl_A <= stream.in_data;
        tbl_B <= b_word;
      end
    end
  end

`ifdef TBL_SEED_LOADER_CKSUM_EN
  logic [DATA_W-1:0] exp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cksum <= '0;
      exp_q <= '0;
    end else if (start_idle) begin
      cksum <= '0;
      exp_q <= exp_cksum;
    end else if (accept) begin
      cksum <= cksum ^ stream.in_data;
    end
  end

  // By DONE the last accepted word has already been folded into cksum.
  assign cksum_err = (state_q == S_DONE) && (cksum != exp_q);
`endif

endmodule

// File: tb/tb_tbl_seed_loader.sv
// ---------------------------------------------------------------------------
// tb_tbl_seed_loader
//   Self-checking bench for tbl_seed_loader. Loads are described by a table
//   of requests plus randomized requests; a scoreboard computes the expected
//   write stream (index = start_addr + n, data = n-th accepted word) from
//   the request and the words offered, and checks every cycle.
// ---------------------------------------------------------------------------
module tb_tbl_seed_loader;

  localparam int DEPTH  = 320;
  localparam int DATA_W = 68;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [8:0]        start_addr;
  logic [8:0]        count;
  logic [DATA_W-1:0] tbl_A, tbl_B;
  logic              tbl_is_write, busy, done, err;
`ifdef TBL_SEED_LOADER_CKSUM_EN
  logic [DATA_W-1:0] exp_cksum;
  logic [DATA_W-1:0] cksum;
  logic              cksum_err;
`endif

  tbl_seed_loader_if #(.DATA_W(DATA_W)) sif ();

  tbl_seed_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_addr   (start_addr),
    .count        (count),
    .stream       (sif.slave),
`ifdef TBL_SEED_LOADER_CKSUM_EN
    .exp_cksum    (exp_cksum),
    .cksum        (cksum),
    .cksum_err    (cksum_err),
`endif
    .tbl_A        (tbl_A),
    .tbl_B        (tbl_B),
    .tbl_is_write (tbl_is_write),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard view of what tbl_A/tbl_B should currently hold.
  logic [DATA_W-1:0] last_a, last_b;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] idx_word(input int idx);
    logic [DATA_W-1:0] b;
    b = '0;
    b[53:45] = 9'(idx);
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] rnd68();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DATA_W-1:0];
  endfunction

  // Valid pattern for the stall test, one entry per LOAD cycle.
  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // vmode: 0 valid always, data=index; 1 random valid, random data;
  //        2 fixed stall pattern, random data; 3 valid always, data=1<<n.
  // abort_at: if >0, pulse rst once that many writes have been observed.
  // poke: drive stray start pulses while the load is running.
  task automatic run_load(input int addr, input int cnt, input bit exp_err,
                          input int vmode, input int abort_at, input bit poke,
                          input logic [DATA_W-1:0] exp_ck);
    int acc = 0;
    int wr = 0;
    int cyc = 0;
    int budget;
    bit pend = 0;
    bit v;
    bit seen;
    int pend_idx = 0;
    logic [DATA_W-1:0] pend_data = '0;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] ck_model = '0;

    budget = 10 * cnt + 50;
    start      = 1'b1;
    start_addr = 9'(addr);
    count      = 9'(cnt);
`ifdef TBL_SEED_LOADER_CKSUM_EN
    exp_cksum  = exp_ck;
`endif
    step();
    start = 1'b0;

    if (exp_err) begin
      check("err_pulse", {67'b0, err}, 1);
      check("err_busy", {67'b0, busy}, 0);
      check("err_ready", {67'b0, sif.in_ready}, 0);
      step();
      check("err_one_cycle", {67'b0, err}, 0);
      check("err_no_write", {67'b0, tbl_is_write}, 0);
      check("err_busy2", {67'b0, busy}, 0);
      check("err_no_done", {67'b0, done}, 0);
      return;
    end

    if (cnt == 0) begin
      seen = 0;
      for (int k = 0; k < 2 && !seen; k++) begin
        if (k > 0) step();
        check("cnt0_no_write", {67'b0, tbl_is_write}, 0);
        check("cnt0_busy", {67'b0, busy}, 0);
        check("cnt0_err", {67'b0, err}, 0);
        if (done) begin
          seen = 1;
`ifdef TBL_SEED_LOADER_CKSUM_EN
          check("cnt0_cksum_err", {67'b0, cksum_err}, {67'b0, exp_ck != '0});
`endif
        end
      end
      check("cnt0_done_seen", {67'b0, seen}, 1);
      step();
      check("cnt0_done_once", {67'b0, done}, 0);
      check("cnt0_no_write2", {67'b0, tbl_is_write}, 0);
      return;
    end

    while (1) begin
      check("strobe", {67'b0, tbl_is_write}, {67'b0, pend});
      if (pend) begin
        last_a = pend_data;
        last_b = idx_word(pend_idx);
        wr++;
      end
      check("tbl_A", tbl_A, last_a);
      check("tbl_B", tbl_B, last_b);
      check("busy", {67'b0, busy}, 1);
      check("in_ready", {67'b0, sif.in_ready}, {67'b0, acc < cnt});
      check("no_err", {67'b0, err}, 0);
      check("no_done", {67'b0, done}, 0);

      if (abort_at > 0 && wr == abort_at) begin
        sif.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_a = '0;
        last_b = '0;
        check("rst_strobe", {67'b0, tbl_is_write}, 0);
        check("rst_busy", {67'b0, busy}, 0);
        check("rst_ready", {67'b0, sif.in_ready}, 0);
        check("rst_tbl_A", tbl_A, '0);
        for (int k = 0; k < 3; k++) begin
          check("rst_no_done", {67'b0, done}, 0);
          check("rst_idle_busy", {67'b0, busy}, 0);
          step();
        end
        return;
      end

      if (wr == cnt) break;
      if (cyc >= budget) begin
        check("load_timeout", 0, 1);
        sif.in_valid = 1'b0;
        return;
      end

      if (poke) begin
        if (cyc == 2) begin
          start = 1'b1; start_addr = 9'd0; count = 9'd0;
        end else if (cyc == 3) begin
          start_addr = 9'd400; count = 9'd300;
        end else if (cyc == 4) begin
          start = 1'b0;
        end
      end

      unique case (vmode)
        0: begin v = 1'b1; d = DATA_W'(addr + acc); end
        1: begin v = ($urandom_range(0, 9) < 6); d = rnd68(); end
        2: begin v = (cyc < 7) ? pat[cyc] : 1'b1; d = rnd68(); end
        default: begin v = 1'b1; d = DATA_W'(1) << acc; end
      endcase
      sif.in_valid = v;
      sif.in_data  = d;
      pend = v && (acc < cnt);
      if (pend) begin
        pend_data = d;
        pend_idx  = addr + acc;
        ck_model  = ck_model ^ d;
        acc++;
      end
      step();
      cyc++;
    end

    sif.in_valid = 1'b0;
    step();
    check("done_pulse", {67'b0, done}, 1);
    check("done_busy", {67'b0, busy}, 0);
    check("done_no_write", {67'b0, tbl_is_write}, 0);
    check("done_hold_A", tbl_A, last_a);
`ifdef TBL_SEED_LOADER_CKSUM_EN
    check("cksum_val", cksum, ck_model);
    check("cksum_err", {67'b0, cksum_err}, {67'b0, ck_model != exp_ck});
`endif
    step();
    check("done_once", {67'b0, done}, 0);
    check("idle_ready", {67'b0, sif.in_ready}, 0);
  endtask

  typedef struct {
    int addr;
    int cnt;
    bit exp_err;
    int vmode;
    int abort_at;
    bit poke;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{0,   320, 1'b0, 0, 0, 1'b0};  // full table, back to back
    vecs[1]  = '{300, 21,  1'b1, 0, 0, 1'b0};  // one past the end
    vecs[2]  = '{300, 20,  1'b0, 1, 0, 1'b0};  // ends exactly at 319
    vecs[3]  = '{319, 1,   1'b0, 0, 0, 1'b0};  // last index alone
    vecs[4]  = '{319, 2,   1'b1, 0, 0, 1'b0};
    vecs[5]  = '{0,   321, 1'b1, 0, 0, 1'b0};
    vecs[6]  = '{400, 1,   1'b1, 0, 0, 1'b0};
    vecs[7]  = '{10,  4,   1'b0, 2, 0, 1'b0};  // stall pattern
    vecs[8]  = '{50,  10,  1'b0, 0, 5, 1'b0};  // reset after 5 writes
    vecs[9]  = '{50,  10,  1'b0, 1, 0, 1'b0};  // fresh load after reset
    vecs[10] = '{7,   0,   1'b0, 0, 0, 1'b0};  // empty load
    vecs[11] = '{20,  6,   1'b0, 1, 0, 1'b1};  // stray starts mid-load

    rst = 1'b1;
    start = 1'b0;
    start_addr = '0;
    count = '0;
    sif.in_valid = 1'b0;
    sif.in_data = '0;
`ifdef TBL_SEED_LOADER_CKSUM_EN
    exp_cksum = '0;
`endif
    last_a = '0;
    last_b = '0;
    step();
    step();
    check("rst_in_ready", {67'b0, sif.in_ready}, 0);
    check("rst_is_write", {67'b0, tbl_is_write}, 0);
    check("rst_A", tbl_A, '0);
    check("rst_B", tbl_B, '0);
    check("rst_busy", {67'b0, busy}, 0);
    check("rst_done", {67'b0, done}, 0);
    check("rst_err", {67'b0, err}, 0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_load(vecs[i].addr, vecs[i].cnt, vecs[i].exp_err, vecs[i].vmode,
               vecs[i].abort_at, vecs[i].poke, '0);
    end

`ifdef TBL_SEED_LOADER_CKSUM_EN
    run_load(100, 3, 1'b0, 3, 0, 1'b0, DATA_W'(7));
    run_load(100, 3, 1'b0, 3, 0, 1'b0, DATA_W'(6));
    run_load(5, 0, 1'b0, 0, 0, 1'b0, DATA_W'(3));
`endif

    for (int r = 0; r < 24; r++) begin
      int a, c;
      if (r % 4 == 3) begin
        a = $urandom_range(0, 340);
        c = $urandom_range(1, 330);
      end else begin
        a = $urandom_range(0, 330);
        c = $urandom_range(0, 24);
      end
      if (c == 0) a = a % DEPTH;
      run_load(a, c, (a + c) > DEPTH, 1, 0, 1'b0, rnd68());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
